board_ram_ctrl: RTL and testbench
=================================

Name: board_ram_ctrl

Overview:
- Owns one 10x10 battleship board: 100 tiles of 2 bits each.
- Executes CLEAR, PLACE and FIRE commands from the game-logic side over a valid/ready handshake.
- Serves the screen renderer's tile-read port: 10-bit address in, 2-bit tile code out.
- Two instances are built, one per board ("us" and "them"), directly upstream of the tile renderer.

Parameters:
- ROWS, 10, board rows.
- COLS, 10, board columns.
- TILES, 100, ROWS*COLS; highest valid address is TILES-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=NOP, 1=CLEAR, 2=PLACE, 3=FIRE.
- cmd_row  in  4  row 0..9.
- cmd_col  in  4  column 0..9.
- rsp_valid  out  1  result available; held until accepted.
- rsp_ready  in  1  result accept.
- rsp_code  out  3  0=OK, 1=HIT, 2=MISS, 3=REPEAT, 4=BLOCKED, 5=BADADDR.
- vid_addr  in  10  renderer tile address, row*10+col.
- vid_data  out  2  tile code: EMPTY=0, HIT=1, MISS=2, SHIP=3.
- ships_left  out  7  SHIP tiles not yet hit.
- all_sunk  out  1  high when ships_left==0 and at least one ship has been placed since the last CLEAR.

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_code=0, vid_data=0, ships_left=0, all_sunk=0.
- On reset release the FSM enters CLEAR automatically.
- FSM states: CLEAR, IDLE, RD, WR, RESP.
- CLEAR:
  - Writes EMPTY to address 0..99, one address per cycle: 100 cycles.
  - Zeroes ships_left and the placed flag.
  - Reset-initiated clear goes straight to IDLE with no response.
  - Command-initiated clear goes to RESP with OK.
- IDLE: cmd_ready=1. A handshake (cmd_valid&cmd_ready) at cycle T latches op, row and col.
  - NOP: no state change, no response.
  - Row>9 or col>9 on PLACE/FIRE: go to RESP with BADADDR; no memory access.
  - Otherwise addr = row*10+col, computed as (row<<3)+(row<<1)+col, 7 bits; go to RD.
- RD (T+1): memory read issued; data registered at end of cycle.
- WR (T+2): decide from the read tile:
  - FIRE on SHIP: write HIT, ships_left-1, code HIT.
  - FIRE on EMPTY: write MISS, code MISS.
  - FIRE on HIT or MISS: no write, code REPEAT.
  - PLACE on EMPTY: write SHIP, ships_left+1, set placed flag, code OK.
  - PLACE on any other tile: no write, code BLOCKED.
- RESP (T+3): rsp_valid=1 with rsp_code stable. Leave for IDLE on the cycle rsp_valid&rsp_ready; rsp_valid=0 the next cycle.
  - cmd_ready stays 0 from T+1 until back in IDLE, so at most one command is in flight.
  - Back-to-back throughput is one command per 4 cycles when rsp_ready is held high.
- ships_left saturates: never exceeds 100, never drops below 0.
- all_sunk is registered, updated the cycle after ships_left changes.
- Video port:
  - Independent read port with 1-cycle latency: vid_data at cycle N+1 reflects vid_addr at cycle N.
  - vid_addr >= 100 returns EMPTY.
  - A same-cycle write and video read of the same address returns the old value (read-first).
  - The video port is never stalled by commands or by CLEAR.
  - During CLEAR, tiles not yet swept may still show their old value.
- Reset mid-operation aborts any command, drops rsp_valid and restarts the CLEAR sweep from address 0.

Decomposition:
- Shared package board_pkg holds:
  - tile codes EMPTY/HIT/MISS/SHIP;
  - op codes NOP/CLEAR/PLACE/FIRE;
  - response codes OK..BADADDR;
  - ROWS/COLS/TILES constants.
  - The screen renderer uses the same tile codes from this package.
- One sub-module, board_mem: 128x2 simple dual-port synchronous RAM.
  - Port A: write plus synchronous read, for the FSM.
  - Port B: read-only, for video.
  - Out-of-range masking is done in board_ram_ctrl, not in board_mem.

Test Plan:
- Reset release -> cmd_ready low for exactly 100 cycles, then high; every vid_addr 0..127 reads 0; ships_left=0, all_sunk=0.
- PLACE (3,4) -> rsp_valid at T+3 with OK; vid_addr=34 reads 3; ships_left=1. Second PLACE (3,4) -> BLOCKED, ships_left stays 1.
- FIRE (3,4) -> HIT, vid_addr=34 reads 1, ships_left=0, all_sunk=1 one cycle later. FIRE (3,4) again -> REPEAT. FIRE (0,0) -> MISS, addr 0 reads 2.
- PLACE (10,2) and FIRE (2,15) -> BADADDR; no tile changes anywhere (check all 100 addresses).
- Hold rsp_ready=0 for 20 cycles after a FIRE -> rsp_valid and rsp_code stable, cmd_ready=0, a second cmd_valid is ignored. Release -> one transfer only.
- Sweep vid_addr 0..99 continuously while issuing PLACE (9,9) -> read of 99 in the write cycle returns 0; the following read returns 3. Assert rst low mid-sweep of a command CLEAR -> rsp_valid drops, full 100-cycle re-clear follows.

Source files
------------

// File: rtl/board_pkg.sv
// Shared definitions for the battleship board: geometry, tile codes,
// command op codes and response codes. The tile renderer imports the
// same tile codes so both sides agree on what each 2-bit value means.
package board_pkg;

    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int TILES = ROWS * COLS;

    // Physical RAM depth: next power of two above TILES
    localparam int MEM_AW    = 7;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_HIT   = 2'd1,
        TILE_MISS  = 2'd2,
        TILE_SHIP  = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_CLEAR = 2'd1,
        OP_PLACE = 2'd2,
        OP_FIRE  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        RSP_OK      = 3'd0,
        RSP_HIT     = 3'd1,
        RSP_MISS    = 3'd2,
        RSP_REPEAT  = 3'd3,
        RSP_BLOCKED = 3'd4,
        RSP_BADADDR = 3'd5
    } rsp_t;

    // Linear tile address row*10+col built from shifts and adds so no
    // multiplier is needed; only valid for row/col already range-checked.
    function automatic logic [MEM_AW-1:0] tileAddr(input logic [3:0] row,
                                                   input logic [3:0] col);
        logic [MEM_AW-1:0] rowW;
        logic [MEM_AW-1:0] colW;
        rowW = {3'b000, row};
        colW = {3'b000, col};
        return (rowW << 3) + (rowW << 1) + colW;
    endfunction

endpackage

// File: rtl/board_mem.sv
// 128x2 simple dual-port synchronous RAM holding the board tiles.
// Port A is the read/write port used by the command FSM; port B is a
// read-only port for the video renderer. Both reads are read-first.
module board_mem
    import board_pkg::*;
(
    input  logic              clk,
    input  logic              i_aWe,
    input  logic [MEM_AW-1:0] i_aAddr,
    input  logic [1:0]        i_aWdata,
    output logic [1:0]        o_aRdata,
    input  logic [MEM_AW-1:0] i_bAddr,
    output logic [1:0]        o_bRdata
);

    logic [1:0] r_mem [MEM_DEPTH];
    logic [1:0] r_aRdata;
    logic [1:0] r_bRdata;

    // Port A: write and registered read of the old contents
    always_ff @(posedge clk) begin
        if (i_aWe) begin
            r_mem[i_aAddr] <= i_aWdata;
        end
        r_aRdata <= r_mem[i_aAddr];
    end

    // Port B: registered read for the renderer, never stalled
    always_ff @(posedge clk) begin
        r_bRdata <= r_mem[i_bAddr];
    end

    assign o_aRdata = r_aRdata;
    assign o_bRdata = r_bRdata;

endmodule

// File: rtl/board_ram_ctrl.sv
// Battleship board controller: owns one 10x10 tile board, executes
// CLEAR/PLACE/FIRE commands over a valid/ready handshake and serves the
// renderer's tile read port. A sweep clears the board after reset and on
// a CLEAR command; PLACE/FIRE do a read-decide-write over RD and WR.
module board_ram_ctrl
    import board_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_row,
    input  logic [3:0] cmd_col,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_code,
    input  logic [9:0] vid_addr,
    output logic [1:0] vid_data,
    output logic [6:0] ships_left,
    output logic       all_sunk
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RESP
    } state_t;

    state_t            r_state;
    op_t               r_op;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_AW-1:0] r_clrAddr;
    logic              r_clrFromCmd;
    logic              r_cmdReady;
    logic              r_rspValid;
    rsp_t              r_rspCode;
    logic [6:0]        r_shipsLeft;
    logic              r_placed;
    logic              r_allSunk;
    logic              r_vidMask;

    logic              w_aWe;
    logic [MEM_AW-1:0] w_aAddr;
    logic [1:0]        w_aWdata;
    logic [1:0]        w_aRdata;
    logic [1:0]        w_bRdata;

    logic              w_decWrite;
    tile_t             w_decTile;
    rsp_t              w_decCode;
    logic              w_badAddr;

    assign w_badAddr = (cmd_row > 4'(ROWS - 1)) || (cmd_col > 4'(COLS - 1));

    // Decide the write-back and response from the tile read in RD
    always_comb begin
        w_decWrite = 1'b0;
        w_decTile  = TILE_EMPTY;
        w_decCode  = RSP_OK;
        if (r_op == OP_FIRE) begin
            case (tile_t'(w_aRdata))
                TILE_SHIP: begin
                    w_decWrite = 1'b1;
                    w_decTile  = TILE_HIT;
                    w_decCode  = RSP_HIT;
                end
                TILE_EMPTY: begin
                    w_decWrite = 1'b1;
                    w_decTile  = TILE_MISS;
                    w_decCode  = RSP_MISS;
                end
                default: begin
                    w_decCode  = RSP_REPEAT;
                end
            endcase
        end else begin
            if (tile_t'(w_aRdata) == TILE_EMPTY) begin
                w_decWrite = 1'b1;
                w_decTile  = TILE_SHIP;
                w_decCode  = RSP_OK;
            end else begin
                w_decCode  = RSP_BLOCKED;
            end
        end
    end

    // Port A is owned by the clear sweep in CLEAR and by the command in WR
    always_comb begin
        w_aWe    = 1'b0;
        w_aAddr  = r_addr;
        w_aWdata = TILE_EMPTY;
        if (r_state == ST_CLEAR) begin
            w_aWe    = 1'b1;
            w_aAddr  = r_clrAddr;
            w_aWdata = TILE_EMPTY;
        end else if (r_state == ST_WR) begin
            w_aWe    = w_decWrite;
            w_aWdata = w_decTile;
        end
    end

    board_mem u_mem (
        .clk      (clk),
        .i_aWe    (w_aWe),
        .i_aAddr  (w_aAddr),
        .i_aWdata (w_aWdata),
        .o_aRdata (w_aRdata),
        .i_bAddr  (vid_addr[MEM_AW-1:0]),
        .o_bRdata (w_bRdata)
    );

    // Command FSM with registered handshake, response and ship count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_CLEAR;
            r_op         <= OP_NOP;
            r_addr       <= '0;
            r_clrAddr    <= '0;
            r_clrFromCmd <= 1'b0;
            r_cmdReady   <= 1'b0;
            r_rspValid   <= 1'b0;
            r_rspCode    <= RSP_OK;
            r_shipsLeft  <= '0;
            r_placed     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_shipsLeft <= '0;
                    r_placed    <= 1'b0;
                    if (r_clrAddr == MEM_AW'(TILES - 1)) begin
                        r_clrAddr <= '0;
                        if (r_clrFromCmd) begin
                            r_state    <= ST_RESP;
                            r_rspValid <= 1'b1;
                            r_rspCode  <= RSP_OK;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_cmdReady <= 1'b1;
                        end
                    end else begin
                        r_clrAddr <= r_clrAddr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid && r_cmdReady) begin
                        r_op <= op_t'(cmd_op);
                        case (op_t'(cmd_op))
                            OP_CLEAR: begin
                                r_cmdReady   <= 1'b0;
                                r_clrFromCmd <= 1'b1;
                                r_clrAddr    <= '0;
                                r_state      <= ST_CLEAR;
                            end
                            OP_PLACE, OP_FIRE: begin
                                r_cmdReady <= 1'b0;
                                if (w_badAddr) begin
                                    r_state    <= ST_RESP;
                                    r_rspValid <= 1'b1;
                                    r_rspCode  <= RSP_BADADDR;
                                end else begin
                                    r_addr  <= tileAddr(cmd_row, cmd_col);
                                    r_state <= ST_RD;
                                end
                            end
                            default: begin
                                r_state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_rspCode  <= w_decCode;
                    r_rspValid <= 1'b1;
                    r_state    <= ST_RESP;
                    if (w_decWrite && (w_decTile == TILE_HIT) && (r_shipsLeft != '0)) begin
                        r_shipsLeft <= r_shipsLeft - 1'b1;
                    end
                    if (w_decWrite && (w_decTile == TILE_SHIP)) begin
                        r_placed <= 1'b1;
                        if (r_shipsLeft < 7'(TILES)) begin
                            r_shipsLeft <= r_shipsLeft + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // all_sunk follows the ship count one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_allSunk <= 1'b0;
        end else begin
            r_allSunk <= (r_shipsLeft == '0) && r_placed;
        end
    end

    // Remember whether the video address being read is off the board
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vidMask <= 1'b1;
        end else begin
            r_vidMask <= (vid_addr >= 10'(TILES));
        end
    end

    assign vid_data   = r_vidMask ? TILE_EMPTY : w_bRdata;
    assign cmd_ready  = r_cmdReady;
    assign rsp_valid  = r_rspValid;
    assign rsp_code   = r_rspCode;
    assign ships_left = r_shipsLeft;
    assign all_sunk   = r_allSunk;

endmodule

// File: tb/tb_board_ram_ctrl.sv
// Self-checking bench for board_ram_ctrl: directed scenarios followed by
// random commands, all checked against a plain array model of the board.
module tb_board_ram_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_row;
    logic [3:0] cmd_col;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_code;
    logic [9:0] vid_addr;
    logic [1:0] vid_data;
    logic [6:0] ships_left;
    logic       all_sunk;

    int testCount = 0;
    int failCount = 0;

    // Reference model state
    int board [100];
    int mShips;
    bit mPlaced;

    board_ram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_code   (rsp_code),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .ships_left (ships_left),
        .all_sunk   (all_sunk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Board model: a cleared board has no ships and nothing placed
    function automatic void modelClear();
        for (int i = 0; i < 100; i++) board[i] = 0;
        mShips  = 0;
        mPlaced = 0;
    endfunction

    // Apply one command to the model; returns expected code and latency
    function automatic void modelCmd(input int op, input int row, input int col,
                                     output int code, output int lat);
        int idx;
        code = 0;
        lat  = 3;
        if (op == 1) begin
            modelClear();
            lat = 101;
        end else if (row > 9 || col > 9) begin
            code = 5;
            lat  = 1;
        end else begin
            idx = row * 10 + col;
            if (op == 3) begin
                if (board[idx] == 3) begin
                    board[idx] = 1;
                    if (mShips > 0) mShips--;
                    code = 1;
                end else if (board[idx] == 0) begin
                    board[idx] = 2;
                    code = 2;
                end else begin
                    code = 3;
                end
            end else begin
                if (board[idx] == 0) begin
                    board[idx] = 3;
                    if (mShips < 100) mShips++;
                    mPlaced = 1;
                    code = 0;
                end else begin
                    code = 4;
                end
            end
        end
    endfunction

    function automatic int expTile(input int addr);
        return (addr < 100) ? board[addr] : 0;
    endfunction

    task automatic readVid(input int addr, output logic [1:0] d);
        vid_addr = 10'(addr);
        tick();
        d = vid_data;
    endtask

    task automatic checkBoard(input string tag, input int upto);
        logic [1:0] d;
        for (int a = 0; a < upto; a++) begin
            readVid(a, d);
            checkOutput(tag, d, expTile(a));
        end
    endtask

    // Count cycles from reset release until cmd_ready rises
    task automatic waitClearDone(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_ready && n < 300);
        checkOutput(tag, n, 100);
    endtask

    // Issue one command, optionally hold off the response and poke cmd_valid
    task automatic applyStimulus(input int op, input int row, input int col,
                                 input int hold, input bit poke);
        int expCode;
        int expLat;
        int lat;
        int n;
        logic [2:0] code0;
        n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        checkOutput("cmdReadyWait", cmd_ready, 1);
        modelCmd(op, row, col, expCode, expLat);
        cmd_op    = 2'(op);
        cmd_row   = 4'(row);
        cmd_col   = 4'(col);
        cmd_valid = 1'b1;
        tick();
        lat = 1;
        cmd_valid = 1'b0;
        checkOutput("cmdReadyBusy", cmd_ready, 0);
        while (!rsp_valid && lat < 400) begin
            tick();
            lat++;
        end
        checkOutput("rspLatency", lat, expLat);
        checkOutput("rspCode", rsp_code, expCode);
        code0 = rsp_code;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'd3;
                cmd_row   = 4'd0;
                cmd_col   = 4'd1;
            end
            tick();
            checkOutput("holdValid", rsp_valid, 1);
            checkOutput("holdCode", rsp_code, code0);
            checkOutput("holdReady", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("rspDrop", rsp_valid, 0);
        checkOutput("backIdle", cmd_ready, 1);
        checkOutput("shipsLeft", ships_left, mShips);
        checkOutput("allSunk", all_sunk, (mShips == 0 && mPlaced) ? 1 : 0);
        if (poke) begin
            tick();
            checkOutput("oneXfer", rsp_valid, 0);
            checkOutput("oneXferReady", cmd_ready, 1);
        end
    endtask

    initial begin
        logic [1:0] d;
        int op;
        int row;
        int col;
        int expCode;
        int expLat;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_row   = 4'd0;
        cmd_col   = 4'd0;
        rsp_ready = 1'b0;
        vid_addr  = 10'd0;
        modelClear();

        // Reset values
        repeat (3) tick();
        checkOutput("rstCmdReady", cmd_ready, 0);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstRspCode", rsp_code, 0);
        checkOutput("rstVidData", vid_data, 0);
        checkOutput("rstShips", ships_left, 0);
        checkOutput("rstAllSunk", all_sunk, 0);
        rst = 1'b1;
        waitClearDone("clearCycles");
        checkOutput("postClrShips", ships_left, 0);
        checkOutput("postClrSunk", all_sunk, 0);
        checkOutput("postClrRsp", rsp_valid, 0);
        checkBoard("clrBoard", 128);

        // Directed place/fire sequence
        applyStimulus(2, 3, 4, 0, 0);
        readVid(34, d);
        checkOutput("vid34Ship", d, 3);
        applyStimulus(2, 3, 4, 0, 0);
        applyStimulus(3, 3, 4, 0, 0);
        readVid(34, d);
        checkOutput("vid34Hit", d, 1);
        applyStimulus(3, 3, 4, 0, 0);
        applyStimulus(3, 0, 0, 0, 0);
        readVid(0, d);
        checkOutput("vid0Miss", d, 2);

        // NOP is accepted but produces nothing
        cmd_op    = 2'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("nopReady", cmd_ready, 1);
        tick();
        checkOutput("nopNoRsp", rsp_valid, 0);

        // Out-of-range coordinates
        applyStimulus(2, 10, 2, 0, 0);
        applyStimulus(3, 2, 15, 0, 0);
        checkBoard("badAddrBoard", 100);

        // Held response with an ignored second command
        applyStimulus(3, 5, 5, 20, 1);
        checkBoard("holdBoard", 100);

        // Command-initiated clear
        applyStimulus(2, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkBoard("cmdClrBoard", 100);

        // Read-first collision on the PLACE write cycle
        cmd_op    = 2'd2;
        cmd_row   = 4'd9;
        cmd_col   = 4'd9;
        cmd_valid = 1'b1;
        vid_addr  = 10'd97;
        tick();
        cmd_valid = 1'b0;
        vid_addr  = 10'd98;
        tick();
        vid_addr  = 10'd99;
        tick();
        modelCmd(2, 9, 9, expCode, expLat);
        checkOutput("rdFirstOld", vid_data, 0);
        checkOutput("sweepRsp", rsp_valid, 1);
        checkOutput("sweepCode", rsp_code, expCode);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rdFirstNew", vid_data, 3);
        checkOutput("sweepShips", ships_left, mShips);

        // Reset in the middle of a command clear
        cmd_op    = 2'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (40) tick();
        rst = 1'b0;
        #1;
        checkOutput("midRstRsp", rsp_valid, 0);
        checkOutput("midRstReady", cmd_ready, 0);
        tick();
        rst = 1'b1;
        modelClear();
        waitClearDone("reClearCycles");
        checkOutput("reClrRsp", rsp_valid, 0);
        checkOutput("reClrShips", ships_left, 0);
        checkBoard("reClrBoard", 100);

        // Random commands against the model
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 99);
            if (op < 3) op = 1;
            else if (op < 50) op = 2;
            else op = 3;
            row = $urandom_range(0, 11);
            col = $urandom_range(0, 11);
            applyStimulus(op, row, col, $urandom_range(0, 3), 0);
            op = $urandom_range(0, 127);
            readVid(op, d);
            checkOutput("randVid", d, expTile(op));
        end
        checkBoard("finalBoard", 128);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
